// File: rtl/prio_encoder_seq_if.sv
// Request/result bundle between a request source and one downstream consumer of the
// priority encoder. The master drives requests, enable, mode and ready.
interface prio_encoder_seq_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic         ein;
    logic         mode;
    logic [N-1:0] req;
    logic         ready;
    logic [W-1:0] y;
    logic         valid;
    logic         gs;
    logic         eout;

    modport master (
        output ein,
        output mode,
        output req,
        output ready,
        input  y,
        input  valid,
        input  gs,
        input  eout
    );

    modport slave (
        input  ein,
        input  mode,
        input  req,
        input  ready,
        output y,
        output valid,
        output gs,
        output eout
    );
endinterface

// File: rtl/prio_encoder_seq.sv
// Registered N-to-log2(N) priority encoder with fixed or round-robin priority and
// ein/gs/eout cascade flags; the captured index is held under a valid/ready handshake.
module prio_encoder_seq #(
    parameter int N = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    prio_encoder_seq_if.slave      bus,
    output logic [0:0]             state_o
);
    localparam int W = $clog2(N);
    localparam logic [W-1:0] LAST_IDX = W'(N - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Handshake: y is meaningful while valid is high; a transfer happens at every
    // rising edge where valid & ready, and y never changes while valid & ~ready.

    logic [0:0]   state_q, state_d;
    logic [W-1:0] y_q, y_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic         eout_q, eout_d;

    logic         valid;
    logic         accept;
    logic         cap_ok;
    logic [W-1:0] fx_win;
    logic [W-1:0] rr_win;
    logic [W-1:0] win;

    assign valid  = (state_q == ST_HOLD);
    assign accept = valid & bus.ready;
    assign cap_ok = bus.ein & (|bus.req);

    // The pointer moves on the accept edge, and a capture on that same edge already
    // searches from the moved pointer, so the winner logic reads ptr_d.
    always_comb begin
        ptr_d = ptr_q;
        if (accept && bus.mode) begin
            ptr_d = (y_q == '0) ? LAST_IDX : (y_q - 1'b1);
        end
    end

    always_comb begin
        logic [W-1:0] i_w;
        fx_win = '0;
        i_w    = '0;
        for (int i = 0; i < N; i++) begin
            i_w = W'(i);
            if (bus.req[i_w]) begin
                fx_win = i_w;
            end
        end
    end

    // Descending search from the pointer, wrapping from index 0 back to N-1.
    always_comb begin
        int           idx;
        logic [W-1:0] idx_w;
        logic         hit;
        rr_win = '0;
        idx    = 0;
        idx_w  = '0;
        hit    = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx   = (int'(ptr_d) >= k) ? (int'(ptr_d) - k) : (int'(ptr_d) + N - k);
            idx_w = W'(idx);
            if (!hit && bus.req[idx_w]) begin
                hit    = 1'b1;
                rr_win = idx_w;
            end
        end
    end

    assign win = bus.mode ? rr_win : fx_win;

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        case (state_q)
            ST_IDLE: begin
                if (cap_ok) begin
                    y_d     = win;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.ready) begin
                    if (cap_ok) begin
                        y_d = win;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign eout_d = bus.ein & ~(|bus.req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            ptr_q   <= LAST_IDX;
            eout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            ptr_q   <= ptr_d;
            eout_q  <= eout_d;
        end
    end

    assign bus.y     = y_q;
    assign bus.valid = valid;
    assign bus.gs    = valid;
    assign bus.eout  = eout_q;
    assign state_o   = state_q;
endmodule

// File: tb/tb_prio_encoder_seq.sv
// Randomised and directed bench for prio_encoder_seq: a reference model predicts each
// captured index into a queue, and a monitor pops and compares on every transfer.
module tb_prio_encoder_seq;
  localparam int N = 8;
  localparam int W = $clog2(N);

  logic clk;
  logic rst_n;
  logic [0:0] state_dbg;

  prio_encoder_seq_if #(.N(N)) bus ();

  prio_encoder_seq #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
    $fatal(1);
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [1:0]   stat_q[$];
  int tests_run;
  int tests_failed;
  bit mon_en;

  // reference model
  bit m_valid;
  int m_y;
  int m_ptr;

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fixed_pick(input logic [N-1:0] r);
    for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
    return 0;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p - k + N) % N;
      if (r[j]) return j;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_y     = 0;
    m_ptr   = N - 1;
    exp_q.delete();
    stat_q.delete();
  endtask

  // driver: one clock of stimulus, with the model predicting the edge it drives
  task automatic step(input bit ein, input bit mode, input logic [N-1:0] req, input bit ready);
    bit acc;
    bit cap;
    bit m_eout;
    @(negedge clk);
    #1;
    bus.ein   = ein;
    bus.mode  = mode;
    bus.req   = req;
    bus.ready = ready;
    acc = m_valid && ready;
    if (acc && mode) m_ptr = (m_y == 0) ? N - 1 : m_y - 1;
    cap = ein && (req != '0) && (!m_valid || ready);
    if (cap) begin
      m_y = mode ? rr_pick(req, m_ptr) : fixed_pick(req);
      exp_q.push_back(W'(m_y));
      m_valid = 1'b1;
    end else if (acc) begin
      m_valid = 1'b0;
    end
    m_eout = ein && (req == '0);
    @(posedge clk);
    stat_q.push_back({m_valid, m_eout});
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, int'(bus.valid), 0);
    check({tag, "_gs"},    int'(bus.gs),    0);
    check({tag, "_eout"},  int'(bus.eout),  0);
    check({tag, "_y"},     int'(bus.y),     0);
  endtask

  // monitor: samples between the input update and the next rising edge
  initial begin
    logic [1:0]   s;
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (mon_en) begin
        if (stat_q.size() > 0) begin
          s = stat_q.pop_front();
          check("valid", int'(bus.valid), int'(s[1]));
          check("gs",    int'(bus.gs),    int'(s[1]));
          check("eout",  int'(bus.eout),  int'(s[0]));
        end
        if (bus.valid && bus.ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_transfer_y", int'(bus.y), -1);
          end else begin
            e = exp_q.pop_front();
            check("y", int'(bus.y), int'(e));
          end
        end
      end
    end
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    mon_en       = 1'b0;
    rst_n        = 1'b0;
    bus.ein      = 1'b0;
    bus.mode     = 1'b0;
    bus.req      = '0;
    bus.ready    = 1'b0;
    model_reset();

    // reset holds everything at zero whatever the inputs do
    repeat (3) begin
      @(negedge clk);
      #1;
      bus.ein   = 1'($urandom);
      bus.mode  = 1'($urandom);
      bus.req   = N'($urandom);
      bus.ready = 1'($urandom);
      #2;
      check_cleared("reset");
    end
    @(negedge clk);
    bus.ein = 1'b0; bus.mode = 1'b0; bus.req = '0; bus.ready = 1'b0;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // fixed priority
    step(1'b1, 1'b0, 8'b0010_0110, 1'b1);
    step(1'b1, 1'b0, 8'b0000_0110, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);

    // round robin, full wrap, then resume after a mode toggle
    repeat (9) step(1'b1, 1'b1, 8'hFF, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    repeat (4) step(1'b1, 1'b1, 8'hFF, 1'b1);
    step(1'b1, 1'b1, 8'h00, 1'b1);

    // backpressure
    step(1'b1, 1'b0, 8'h08, 1'b1);
    repeat (5) step(1'b1, 1'b0, 8'h80, 1'b0);
    step(1'b1, 1'b0, 8'h80, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);

    // enable gating and pending result surviving ein low
    repeat (3) step(1'b0, 1'b0, 8'h10, 1'b1);
    step(1'b1, 1'b0, 8'h04, 1'b0);
    repeat (2) step(1'b0, 1'b0, 8'h10, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h10, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);

    // asynchronous reset in the middle of a held result
    step(1'b1, 1'b0, 8'h40, 1'b0);
    step(1'b1, 1'b0, 8'h40, 1'b0);
    #2;
    check("hold_before_reset_y", int'(bus.y), 6);
    rst_n  = 1'b0;
    mon_en = 1'b0;
    #1;
    check_cleared("mid_reset");
    model_reset();
    bus.ein = 1'b0; bus.mode = 1'b0; bus.req = '0; bus.ready = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (3) step(1'b1, 1'b1, 8'hFF, 1'b1);
    step(1'b1, 1'b1, 8'h00, 1'b1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [N-1:0] r;
      r = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
      step(($urandom_range(0, 5) != 0), 1'($urandom), r, ($urandom_range(0, 3) != 0));
    end

    // drain
    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    #4;
    check("drain_pending", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
